// File: rtl/axis_demux.sv
// Packet-level AXI-Stream demultiplexer: one source fanned out to NUM_SINKS sinks.
// The destination is latched from tuser on the first beat and held until tlast.
module axis_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 8,
  parameter int NUM_SINKS  = 2,
  parameter int DEST_LSB   = 0,
  parameter int DEST_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic                             s_tlast,
  input  logic [USER_WIDTH-1:0]            s_tuser,
  input  logic [DATA_WIDTH-1:0]            s_tdata,
  output logic [NUM_SINKS-1:0]             m_tvalid,
  input  logic [NUM_SINKS-1:0]             m_tready,
  output logic [NUM_SINKS-1:0]             m_tlast,
  output logic [USER_WIDTH*NUM_SINKS-1:0]  m_tuser,
  output logic [DATA_WIDTH*NUM_SINKS-1:0]  m_tdata,
  output logic [CNT_WIDTH-1:0]             drop_count,
  output logic                             busy
);

  if (NUM_SINKS < 1 || NUM_SINKS > 8 || DEST_LSB + DEST_WIDTH > USER_WIDTH ||
      (2 ** DEST_WIDTH) < NUM_SINKS) begin : g_param_err
    $error("axis_demux: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                          state_q, state_d;
  logic [DEST_WIDTH-1:0]           cur_q, cur_d;
  logic [DEST_WIDTH-1:0]           dest;
  logic [NUM_SINKS-1:0]            dest_hot, cur_hot, can_acc, wr_en;
  logic                            dest_ok, acc, drop_inc;
  logic [CNT_WIDTH-1:0]            drop_q;
  logic [NUM_SINKS-1:0]            vld_q, last_q;
  logic [USER_WIDTH*NUM_SINKS-1:0] user_q;
  logic [DATA_WIDTH*NUM_SINKS-1:0] data_q;

  assign dest    = s_tuser[DEST_LSB +: DEST_WIDTH];
  assign can_acc = ~vld_q | m_tready;
  assign acc     = s_tvalid && s_tready;

  // One-hot decode of the incoming and held destinations; out-of-range dest decodes to all-zero.
  always_comb begin
    dest_hot = '0;
    cur_hot  = '0;
    for (int k = 0; k < NUM_SINKS; k++) begin
      dest_hot[k] = (dest == DEST_WIDTH'(k));
      cur_hot[k]  = (cur_q == DEST_WIDTH'(k));
    end
    dest_ok = |dest_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (drop_inc && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (acc && !s_tlast) begin
          if (dest_ok) begin
            state_d = ROUTE;
            cur_d   = dest;
          end else begin
            state_d = DROP;
          end
        end
      end
      ROUTE, DROP: if (acc && s_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready depends only on the addressed slot, never on s_tvalid.
  always_comb begin
    s_tready = 1'b0;
    wr_en    = '0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (dest_ok) begin
          s_tready = |(can_acc & dest_hot);
          if (s_tvalid && s_tready) wr_en = dest_hot;
        end else begin
          s_tready = 1'b1;
          drop_inc = s_tvalid;
        end
      end
      ROUTE: begin
        s_tready = |(can_acc & cur_hot);
        if (s_tvalid && s_tready) wr_en = cur_hot;
      end
      DROP:    s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
  end

  // Output slots: a new write overrides a simultaneous drain so the stream has no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
      user_q <= '0;
      data_q <= '0;
    end else begin
      for (int k = 0; k < NUM_SINKS; k++) begin
        if (wr_en[k]) begin
          vld_q[k]                              <= 1'b1;
          last_q[k]                             <= s_tlast;
          user_q[k*USER_WIDTH +: USER_WIDTH]    <= s_tuser;
          data_q[k*DATA_WIDTH +: DATA_WIDTH]    <= s_tdata;
        end else if (m_tready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign m_tvalid   = vld_q;
  assign m_tlast    = last_q;
  assign m_tuser    = user_q;
  assign m_tdata    = data_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_axis_demux.sv
// Scoreboard bench for axis_demux (2 sinks); a second instance with a 2-bit
// drop counter shares the stimulus to exercise counter saturation.
module tb_axis_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast;
  logic        s_tready, s_tready2;
  logic [7:0]  s_tuser;
  logic [31:0] s_tdata;
  logic [1:0]  m_tready;
  logic [1:0]  m_tvalid, m_tlast, m_tvalid2, m_tlast2;
  logic [15:0] m_tuser, m_tuser2;
  logic [63:0] m_tdata, m_tdata2;
  logic [15:0] drop_count;
  logic [1:0]  drop_count2;
  logic        busy, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drops = 0;
  int busy_cnt = 0;
  logic [40:0] q0[$];
  logic [40:0] q1[$];

  always #5 clk = ~clk;

  axis_demux dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tdata(s_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdata(m_tdata), .drop_count(drop_count),
    .busy(busy)
  );

  axis_demux #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready2), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tdata(s_tdata), .m_tvalid(m_tvalid2), .m_tready(m_tready),
    .m_tlast(m_tlast2), .m_tuser(m_tuser2), .m_tdata(m_tdata2), .drop_count(drop_count2),
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop the expected beat whenever a sink completes a handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_tvalid[k] === 1'b1 && m_tready[k] === 1'b1) begin
        logic [40:0] got, exp;
        got = {m_tlast[k], m_tuser[k*8 +: 8], m_tdata[k*32 +: 32]};
        if (k == 0) begin
          if (q0.size() == 0) chk("sb_unexpected_s0", got, 41'h0);
          else begin exp = q0.pop_front(); chk("sb_s0", got, exp); end
        end else begin
          if (q1.size() == 0) chk("sb_unexpected_s1", got, 41'h0);
          else begin exp = q1.pop_front(); chk("sb_s1", got, exp); end
        end
      end
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic send_beat(input int sink, input logic last, input logic [7:0] user,
                           input logic [31:0] data, inout int stalls);
    bit ok = 0;
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tuser  = user;
    s_tdata  = data;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (s_tready === 1'b1) ok = 1;
      else stalls++;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      s_tvalid = 1'b0;
      return;
    end
    if (sink == 0) q0.push_back({last, user, data});
    if (sink == 1) q1.push_back({last, user, data});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (sink >= 0) begin
      chk("latency_vld", m_tvalid[sink], 1'b1);
      chk("latency_data", m_tdata[sink*32 +: 32], data);
    end
  endtask

  // Later beats flip a dest bit so routing must come from the first beat only.
  task automatic send_pkt(input logic [7:0] user, input int nb, input int nsend,
                          input logic [31:0] base, output int stalls);
    int sink;
    logic [7:0] u;
    sink = (user[2:0] < 3'd2) ? int'(user[2:0]) : -1;
    stalls = 0;
    for (int i = 0; i < nsend; i++) begin
      u = (i == 0) ? user : (user ^ 8'h04);
      send_beat(sink, (i == nb - 1), u, base + 32'(i), stalls);
    end
    if (sink < 0 && nsend == nb) exp_drops++;
  endtask

  initial begin
    int st, tot;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0; s_tdata = '0;
    m_tready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mvalid", m_tvalid, 2'b00);
    chk("rst_mdata", m_tdata, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_count, 16'h0);

    // 4-beat packet to sink 1
    busy_cnt = 0;
    send_pkt(8'h01, 4, 4, 32'h1000, st);
    chk("t1_stall", st, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_busy_cycles", busy_cnt, 3);
    chk("t1_busy_end", busy, 1'b0);

    // back-to-back single-beat packets alternating sinks
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      send_pkt((i % 2 == 0) ? 8'h00 : 8'h01, 1, 1, 32'h2000 + 32'(i * 16), st);
      tot += st;
    end
    chk("t2_stall", tot, 0);
    repeat (2) @(posedge clk);
    #1;

    // sink 0 stalled during a 3-beat packet
    m_tready = 2'b10;
    fork
      send_pkt(8'h00, 3, 3, 32'h3000, st);
      begin
        repeat (4) @(negedge clk);
        chk("t3_sready_low", s_tready, 1'b0);
        chk("t3_held_vld", m_tvalid[0], 1'b1);
        chk("t3_held_data", m_tdata[31:0], 32'h3000);
        @(posedge clk);
        #1;
        m_tready = 2'b11;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // sink 0 holds a beat while a packet flows to sink 1
    m_tready = 2'b10;
    send_pkt(8'h00, 1, 1, 32'h4000, st);
    chk("t4_s0_stall", st, 0);
    send_pkt(8'h01, 2, 2, 32'h4100, st);
    chk("t4_s1_stall", st, 0);
    chk("t4_s0_still_held", m_tvalid[0], 1'b1);
    chk("t4_s0_held_data", m_tdata[31:0], 32'h4000);
    @(posedge clk);
    #1;
    m_tready = 2'b11;
    repeat (2) @(posedge clk);
    #1;

    // out-of-range dest drops; counter saturation on the narrow instance
    chk("t5_drop_before", drop_count, 16'(exp_drops));
    send_pkt(8'h05, 3, 3, 32'h5000, st);
    chk("t5_stall", st, 0);
    chk("t5_drop_one", drop_count, 16'(exp_drops));
    chk("t5_drop2_one", drop_count2, 2'd1);
    for (int i = 0; i < 5; i++) send_pkt(8'h05, 3, 3, 32'h5100 + 32'(i * 16), st);
    chk("t5_drop_six", drop_count, 16'(exp_drops));
    chk("t5_drop2_sat", drop_count2, 2'd3);
    chk("t5_busy", busy, 1'b0);

    // reset mid-packet, then a fresh packet to sink 0
    send_pkt(8'h01, 4, 2, 32'h6000, st);
    chk("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_mvalid", m_tvalid, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_drop", drop_count, 16'h0);
    chk("t6_drop2", drop_count2, 2'd0);
    send_pkt(8'h00, 2, 2, 32'h6100, st);
    chk("t6_stall", st, 0);
    repeat (3) @(posedge clk);
    #1;

    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
